// File: rtl/adc_trigger.sv
// adc_trigger: level/slope trigger detector with hysteresis, post-arm holdoff
// and optional auto-trigger timeout. It drives the level trigger request that
// the capture engine consumes while it waits for a trigger.
module adc_trigger #(
  parameter int DW   = 8,
  parameter int HO_W = 16,
  parameter int TO_W = 24
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sample_en,
  input  logic [2*DW-1:0]   adc_data,
  input  logic              arm,
  input  logic              force_trig,
  input  logic              src,
  input  logic              slope,
  input  logic [1:0]        mode,
  input  logic [DW-1:0]     level,
  input  logic [DW-1:0]     hyst,
  input  logic [HO_W-1:0]   holdoff,
  input  logic [TO_W-1:0]   auto_to,
  output logic              trigger_req,
  output logic              trig_auto,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SEEK  = 2'd2,
    ST_FIRED = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_AUTO  = 2'd2;
  localparam logic [1:0] MODE_FORCE = 2'd3;

  // level - hyst, clamped at zero (computed one bit wider to see the borrow)
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    sat_sub = diff[DW] ? {DW{1'b0}} : diff[DW-1:0];
  endfunction

  // level + hyst, clamped at full scale (computed one bit wider to see the carry)
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
  endfunction

  state_t          state_r, state_nxt_s;
  logic            arm_d_r;
  logic [HO_W-1:0] ho_cnt_r, ho_cnt_nxt_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_nxt_s;
  logic            pre_flag_r, pre_flag_nxt_s;
  logic            trig_req_r;
  logic            trig_auto_r, trig_auto_nxt_s;

  logic [DW-1:0]   sample_s;
  logic [DW-1:0]   lo_s, hi_s;
  logic            precond_s, cross_s, arm_rise_s;
  logic [TO_W:0]   to_cnt_inc_s, auto_eff_s;

  assign sample_s     = src ? adc_data[DW-1:0] : adc_data[2*DW-1:DW];
  assign lo_s         = sat_sub(level, hyst);
  assign hi_s         = sat_add(level, hyst);
  assign precond_s    = slope ? (sample_s > hi_s) : (sample_s < lo_s);
  assign cross_s      = slope ? (sample_s <= level) : (sample_s >= level);
  // arm_d_r resets high so an arm already asserted at reset release is not an edge
  assign arm_rise_s   = arm & ~arm_d_r;
  assign to_cnt_inc_s = {1'b0, to_cnt_r} + {{TO_W{1'b0}}, 1'b1};
  // a zero timeout behaves as one sample
  assign auto_eff_s   = (auto_to == {TO_W{1'b0}}) ? {{TO_W{1'b0}}, 1'b1} : {1'b0, auto_to};

  // Next-state, counter and flag logic; priority is arm drop, force, crossing, timeout
  always_comb begin
    state_nxt_s     = state_r;
    ho_cnt_nxt_s    = ho_cnt_r;
    to_cnt_nxt_s    = to_cnt_r;
    pre_flag_nxt_s  = pre_flag_r;
    trig_auto_nxt_s = trig_auto_r;
    if (mode == MODE_OFF) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm_rise_s) begin
            ho_cnt_nxt_s = holdoff;
            if (holdoff == {HO_W{1'b0}}) begin
              state_nxt_s    = ST_SEEK;
              to_cnt_nxt_s   = {TO_W{1'b0}};
              pre_flag_nxt_s = 1'b0;
            end else begin
              state_nxt_s = ST_HOLD;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!arm) begin
            state_nxt_s = ST_IDLE;
          end else if (force_trig) begin
            state_nxt_s     = ST_FIRED;
            trig_auto_nxt_s = 1'b1;
          end else if (ho_cnt_r == {HO_W{1'b0}}) begin
            state_nxt_s    = ST_SEEK;
            to_cnt_nxt_s   = {TO_W{1'b0}};
            pre_flag_nxt_s = 1'b0;
          end else if (sample_en) begin
            ho_cnt_nxt_s = ho_cnt_r - {{(HO_W-1){1'b0}}, 1'b1};
          end else begin
            ho_cnt_nxt_s = ho_cnt_r;
          end
        end
        ST_SEEK: begin
          if (!arm) begin
            state_nxt_s = ST_IDLE;
          end else if (force_trig) begin
            state_nxt_s     = ST_FIRED;
            trig_auto_nxt_s = 1'b1;
          end else if (sample_en) begin
            if ((mode != MODE_FORCE) && pre_flag_r && cross_s) begin
              state_nxt_s     = ST_FIRED;
              trig_auto_nxt_s = 1'b0;
            end else if ((mode == MODE_AUTO) && (to_cnt_inc_s >= auto_eff_s)) begin
              state_nxt_s     = ST_FIRED;
              trig_auto_nxt_s = 1'b1;
            end else begin
              if (precond_s) begin
                pre_flag_nxt_s = 1'b1;
              end else begin
                pre_flag_nxt_s = pre_flag_r;
              end
              if (mode == MODE_AUTO) begin
                to_cnt_nxt_s = to_cnt_inc_s[TO_W-1:0];
              end else begin
                to_cnt_nxt_s = to_cnt_r;
              end
            end
          end else begin
            state_nxt_s = ST_SEEK;
          end
        end
        ST_FIRED: begin
          if (!arm) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FIRED;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      arm_d_r     <= 1'b1;
      ho_cnt_r    <= {HO_W{1'b0}};
      to_cnt_r    <= {TO_W{1'b0}};
      pre_flag_r  <= 1'b0;
      trig_req_r  <= 1'b0;
      trig_auto_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      arm_d_r     <= arm;
      ho_cnt_r    <= ho_cnt_nxt_s;
      to_cnt_r    <= to_cnt_nxt_s;
      pre_flag_r  <= pre_flag_nxt_s;
      trig_req_r  <= (state_nxt_s == ST_FIRED);
      trig_auto_r <= trig_auto_nxt_s;
    end
  end

  assign trigger_req = trig_req_r;
  assign trig_auto   = trig_auto_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_adc_trigger.sv
// Directed self-checking bench for adc_trigger.
module tb_adc_trigger;

  logic        clk;
  logic        nrst;
  logic        sample_en;
  logic [15:0] adc_data;
  logic        arm;
  logic        force_trig;
  logic        src;
  logic        slope;
  logic [1:0]  mode;
  logic [7:0]  level;
  logic [7:0]  hyst;
  logic [15:0] holdoff;
  logic [23:0] auto_to;
  logic        trigger_req;
  logic        trig_auto;
  logic [1:0]  state_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  adc_trigger #(.DW(8), .HO_W(16), .TO_W(24)) dut (
    .clk(clk), .nrst(nrst), .sample_en(sample_en), .adc_data(adc_data),
    .arm(arm), .force_trig(force_trig), .src(src), .slope(slope), .mode(mode),
    .level(level), .hyst(hyst), .holdoff(holdoff), .auto_to(auto_to),
    .trigger_req(trigger_req), .trig_auto(trig_auto), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n clocks, ending 1 ns after the last rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle sample strobe; the unselected channel carries the inverted value
  task automatic samp(input logic [7:0] v);
    logic [7:0] nv;
    nv = ~v;
    adc_data  = src ? {nv, v} : {v, nv};
    sample_en = 1'b1;
    cyc(1);
    sample_en = 1'b0;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    arm = 1'b0; force_trig = 1'b0; sample_en = 1'b0; adc_data = 16'h0000;
    nrst = 1'b0;
    cyc(2);
    nrst = 1'b1;
    cyc(2);
  endtask

  task automatic rearm();
    arm = 1'b0;
    cyc(1);
    arm = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    arm = 1'b0; force_trig = 1'b0; sample_en = 1'b0; adc_data = 16'h0000;
    nrst = 1'b0;
    cyc(2);
    chk("reset_req", {1'b0, trigger_req}, 2'd0);
    chk("reset_auto", {1'b0, trig_auto}, 2'd0);
    chk("reset_state", state_o, 2'd0);
    // arm held high through reset release must not start a capture
    arm = 1'b1;
    cyc(1);
    nrst = 1'b1;
    cyc(3);
    chk("arm_at_reset_state", state_o, 2'd0);
    arm = 1'b0;
    cyc(2);
  endtask

  task automatic test_rising();
    mode = 2'd1; src = 1'b0; slope = 1'b0; level = 8'd128; hyst = 8'd8; holdoff = 16'd0;
    rearm();
    chk("rise_seek", state_o, 2'd2);
    samp(8'd130);
    chk("rise_nodip_req", {1'b0, trigger_req}, 2'd0);
    samp(8'd125);
    samp(8'd100);
    chk("rise_dip_req", {1'b0, trigger_req}, 2'd0);
    samp(8'd130);
    chk("rise_fire_req", {1'b0, trigger_req}, 2'd1);
    chk("rise_fire_auto", {1'b0, trig_auto}, 2'd0);
    chk("rise_fire_state", state_o, 2'd3);
    arm = 1'b0;
    cyc(1);
    chk("rise_drop_req", {1'b0, trigger_req}, 2'd0);
    chk("rise_drop_state", state_o, 2'd0);
  endtask

  task automatic test_falling();
    mode = 2'd1; src = 1'b1; slope = 1'b1; level = 8'd50; hyst = 8'd10; holdoff = 16'd0;
    rearm();
    samp(8'd70);
    samp(8'd55);
    chk("fall_pre_req", {1'b0, trigger_req}, 2'd0);
    samp(8'd50);
    chk("fall_fire_req", {1'b0, trigger_req}, 2'd1);
    rearm();
    samp(8'd58);
    samp(8'd45);
    chk("fall_nopre_req", {1'b0, trigger_req}, 2'd0);
    chk("fall_nopre_state", state_o, 2'd2);
    arm = 1'b0;
    cyc(1);
    chk("seek_abort_state", state_o, 2'd0);
  endtask

  task automatic test_holdoff();
    mode = 2'd1; src = 1'b0; slope = 1'b0; level = 8'd128; hyst = 8'd8; holdoff = 16'd4;
    rearm();
    chk("ho_state_hold", state_o, 2'd1);
    samp(8'd100);
    samp(8'd130);
    chk("ho_ignored_req", {1'b0, trigger_req}, 2'd0);
    samp(8'd100);
    samp(8'd100);
    chk("ho_still_hold", state_o, 2'd1);
    cyc(1);
    chk("ho_state_seek", state_o, 2'd2);
    samp(8'd130);
    chk("ho_flag_clear_req", {1'b0, trigger_req}, 2'd0);
    samp(8'd100);
    samp(8'd130);
    chk("ho_state_fired", state_o, 2'd3);
    chk("ho_fire_req", {1'b0, trigger_req}, 2'd1);
    arm = 1'b0;
    cyc(1);
  endtask

  task automatic test_auto();
    mode = 2'd2; src = 1'b0; slope = 1'b0; level = 8'd128; hyst = 8'd8; holdoff = 16'd0;
    auto_to = 24'd5;
    rearm();
    repeat (4) samp(8'd128);
    chk("auto_4_req", {1'b0, trigger_req}, 2'd0);
    samp(8'd128);
    chk("auto_5_req", {1'b0, trigger_req}, 2'd1);
    chk("auto_5_auto", {1'b0, trig_auto}, 2'd1);
    arm = 1'b0;
    cyc(1);
    chk("auto_hold_flag", {1'b0, trig_auto}, 2'd1);
    auto_to = 24'd0;
    rearm();
    samp(8'd128);
    chk("auto_zero_req", {1'b0, trigger_req}, 2'd1);
    // crossing and timeout on the same sample: crossing wins
    auto_to = 24'd3;
    rearm();
    samp(8'd100);
    samp(8'd110);
    samp(8'd130);
    chk("auto_tie_req", {1'b0, trigger_req}, 2'd1);
    chk("auto_tie_auto", {1'b0, trig_auto}, 2'd0);
    arm = 1'b0;
    cyc(1);
  endtask

  task automatic test_force();
    mode = 2'd1; holdoff = 16'd1000;
    rearm();
    chk("force_hold_state", state_o, 2'd1);
    force_trig = 1'b1;
    cyc(1);
    force_trig = 1'b0;
    chk("force_req", {1'b0, trigger_req}, 2'd1);
    chk("force_auto", {1'b0, trig_auto}, 2'd1);
    arm = 1'b0;
    cyc(1);
    chk("force_drop_req", {1'b0, trigger_req}, 2'd0);
    chk("force_drop_state", state_o, 2'd0);
  endtask

  task automatic test_modes();
    // force-only mode ignores a valid dip/cross pair
    mode = 2'd3; src = 1'b0; slope = 1'b0; level = 8'd128; hyst = 8'd8; holdoff = 16'd0;
    rearm();
    samp(8'd100);
    samp(8'd130);
    chk("m3_cross_req", {1'b0, trigger_req}, 2'd0);
    force_trig = 1'b1;
    cyc(1);
    force_trig = 1'b0;
    chk("m3_force_req", {1'b0, trigger_req}, 2'd1);
    // mode 0 holds the FSM in IDLE
    mode = 2'd0;
    cyc(1);
    chk("m0_req", {1'b0, trigger_req}, 2'd0);
    rearm();
    chk("m0_state", state_o, 2'd0);
    arm = 1'b0;
    cyc(1);
  endtask

  task automatic test_saturation_reset();
    mode = 2'd1; src = 1'b0; slope = 1'b0; level = 8'd3; hyst = 8'd10; holdoff = 16'd0;
    rearm();
    samp(8'd0);
    samp(8'd5);
    samp(8'd0);
    samp(8'd255);
    chk("sat_req", {1'b0, trigger_req}, 2'd0);
    chk("sat_state", state_o, 2'd2);
    force_trig = 1'b1;
    cyc(1);
    force_trig = 1'b0;
    chk("async_pre_req", {1'b0, trigger_req}, 2'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_req", {1'b0, trigger_req}, 2'd0);
    chk("async_state", state_o, 2'd0);
    cyc(1);
    nrst = 1'b1;
    arm = 1'b0;
    cyc(1);
  endtask

  initial begin
    sample_en = 1'b0; adc_data = 16'h0000; arm = 1'b0; force_trig = 1'b0;
    src = 1'b0; slope = 1'b0; mode = 2'd1; level = 8'd128; hyst = 8'd8;
    holdoff = 16'd0; auto_to = 24'd5; nrst = 1'b0;
    test_reset();
    test_rising();
    test_falling();
    test_holdoff();
    test_auto();
    test_force();
    test_modes();
    do_reset();
    test_saturation_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
